// File: rtl/spi_master_gen2.sv
// SPI master, second generation: all four modes, MSB/LSB-first, 1..DATA_W bit
// frames, tick-based SCLK divider and fixed CS setup/hold/gap half-periods.
module spi_master_gen2 #(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 5,
    parameter int CS_COUNT  = 8,
    parameter int CS_ADDR_W = 3,
    parameter int DIV_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic [DATA_W-1:0]    tx_data,
    output logic [DATA_W-1:0]    rx_data,
    input  logic [LEN_W-1:0]     frame_len,
    input  logic [CS_ADDR_W-1:0] cs_addr,
    input  logic [DIV_W-1:0]     clk_div,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 lsb_first,
    input  logic                 idle_mosi,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic [CS_COUNT-1:0]  cs_n
);

    localparam int EDGE_W = LEN_W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] tx_q, tx_d, sh_q, sh_d, rx_q, rx_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d;
    logic              lsb_q, lsb_d, imo_q, imo_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d;
    logic              done_q, done_d;
    logic [CS_COUNT-1:0] cs_n_q, cs_n_d;

    logic              tick;
    logic [EDGE_W-1:0] edge_n, edge_last;
    logic [LEN_W-1:0]  len_sat, p_tx, p_rx;

    // Order index k of a frame bit -> position within the data word.
    function automatic logic [LEN_W-1:0] bit_pos(
        input logic [LEN_W-1:0] k,
        input logic [LEN_W-1:0] last,
        input logic             lsb
    );
        return lsb ? k : last - k;
    endfunction

    // Active-low one-cold select; addresses past CS_COUNT select nothing.
    function automatic logic [CS_COUNT-1:0] cs_decode(
        input logic [CS_ADDR_W-1:0] a
    );
        logic [CS_COUNT-1:0] r;
        r = '1;
        for (int i = 0; i < CS_COUNT; i++) begin
            if (int'(a) == i) r[i] = 1'b0;
        end
        return r;
    endfunction

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign rx_data = rx_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

    // Next-state logic for the frame sequencer, divider and data path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        edge_d  = edge_q;
        len_d   = len_q;
        tx_d    = tx_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        imo_d   = imo_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        done_d  = 1'b0;

        tick      = (cnt_q == div_q);
        edge_n    = edge_q + EDGE_W'(1);
        edge_last = (EDGE_W'(len_q) + EDGE_W'(1)) << 1;
        len_sat   = (int'(frame_len) >= DATA_W) ? LEN_W'(DATA_W - 1) : frame_len;
        // Shift bit k on edge 2k (cpha=0) or 2k+1 (cpha=1); sample on the
        // following edge, so both reduce to a shift of the edge count.
        p_tx = bit_pos(LEN_W'(edge_n >> 1), len_q, lsb_q);
        p_rx = bit_pos(LEN_W'(edge_q >> 1), len_q, lsb_q);

        if (state_q == S_IDLE) cnt_d = '0;
        else if (tick)         cnt_d = '0;
        else                   cnt_d = cnt_q + DIV_W'(1);

        unique case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = idle_mosi;
                cs_n_d = '1;
                edge_d = '0;
                if (start) begin
                    state_d = S_SETUP;
                    tx_d    = tx_data;
                    len_d   = len_sat;
                    div_d   = clk_div;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    imo_d   = idle_mosi;
                    sh_d    = '0;
                    cs_n_d  = cs_decode(cs_addr);
                    if (!cpha) mosi_d = tx_data[bit_pos('0, len_sat, lsb_first)];
                end
            end
            S_SETUP: begin
                if (tick) state_d = S_XFER;
            end
            S_XFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_n;
                    if (edge_n[0] ^ cpha_q) sh_d[p_rx] = miso;
                    else if (edge_n != edge_last) mosi_d = tx_q[p_tx];
                    if (edge_n == edge_last) begin
                        state_d = S_HOLD;
                        sclk_d  = cpol_q;
                        mosi_d  = imo_q;
                    end
                end
            end
            S_HOLD: begin
                mosi_d = imo_q;
                if (tick) begin
                    state_d = S_GAP;
                    cs_n_d  = '1;
                end
            end
            S_GAP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    rx_d    = sh_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; asynchronous reset to the idle bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            edge_q  <= '0;
            len_q   <= '0;
            tx_q    <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            imo_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            len_q   <= len_d;
            tx_q    <= tx_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            imo_q   <= imo_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_master_gen2.sv
// Bench for spi_master_gen2: table of directed frames, random frames checked
// against a bit-level bus model, plus back-to-back and reset sequences.
module tb_spi_master_gen2;

    localparam int NCS = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] tx_data;
    logic [31:0] rx_data;
    logic [4:0]  frame_len;
    logic [2:0]  cs_addr;
    logic [7:0]  clk_div;
    logic        cpol, cpha, lsb_first, idle_mosi;
    logic        sclk, mosi, miso;
    logic [NCS-1:0] cs_n;

    logic loop_en, miso_drv;
    assign miso = loop_en ? mosi : miso_drv;

    int checks = 0;
    int errors = 0;

    spi_master_gen2 #(
        .DATA_W(32), .LEN_W(5), .CS_COUNT(NCS), .CS_ADDR_W(3), .DIV_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .tx_data(tx_data), .rx_data(rx_data), .frame_len(frame_len),
        .cs_addr(cs_addr), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .idle_mosi(idle_mosi), .sclk(sclk),
        .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] tx;
        int          n;
        int          csa;
        int          div;
        logic        cp, ch, lsb, im, lp;
        logic [31:0] sw;
        logic [31:0] exp_rx;
        int          exp_lat;
    } vec_t;

    vec_t tbl[7];

    // One frame: model expected bus/rx from the rules, watch the bus,
    // act as slave (sw bit k is the k-th bit sent) or loop MOSI back.
    task automatic run_frame(input logic [31:0] tx, input int n,
                             input int csa, input int div,
                             input logic cp, input logic ch,
                             input logic lsb, input logic im,
                             input logic lp, input logic [31:0] sw,
                             output logic [31:0] got_rx,
                             output int got_lat);
        logic [31:0] exp_rx, exp_mo, seen_mo, rx0;
        logic ps, pm, cs_ok, oth_ok, rx_ok, fin;
        int edges, ns, cyc, lat, p;
        exp_rx = '0;
        exp_mo = '0;
        for (int k = 0; k < n; k++) begin
            p = lsb ? k : n - 1 - k;
            exp_mo[k] = tx[p];
            exp_rx[p] = lp ? tx[p] : sw[k];
        end
        lat = (2 * n + 3) * (div + 1);
        tx_data = tx; frame_len = 5'(n - 1); cs_addr = 3'(csa);
        clk_div = 8'(div); cpol = cp; cpha = ch; lsb_first = lsb;
        idle_mosi = im; loop_en = lp; miso_drv = sw[0];
        @(negedge clk);
        chk("idle_sclk", 32'(sclk), 32'(cp));
        chk("idle_mosi", 32'(mosi), 32'(im));
        chk("idle_cs", 32'(cs_n), 32'({NCS{1'b1}}));
        start = 1'b1;
        rx0 = rx_data; ps = sclk; pm = mosi;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        edges = 0; ns = 0; cyc = 0; seen_mo = '0;
        cs_ok = 1'b1; oth_ok = 1'b1; rx_ok = 1'b1; fin = 1'b0;
        while (!fin) begin
            if (sclk !== ps) begin
                edges++;
                if (((edges % 2) == 1) != ch && ns < 32) begin
                    seen_mo[ns] = pm;
                    ns++;
                end
                if (csa < NCS && cs_n[csa] !== 1'b0) cs_ok = 1'b0;
            end
            for (int i = 0; i < NCS; i++)
                if (i != csa && cs_n[i] !== 1'b1) oth_ok = 1'b0;
            if (!done && rx_data !== rx0) rx_ok = 1'b0;
            miso_drv = (ns < 32) ? sw[ns] : 1'b0;
            ps = sclk;
            pm = mosi;
            if (done || cyc >= lat + 40) fin = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        got_lat = cyc;
        got_rx = rx_data;
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", 32'(cyc), 32'(lat));
        chk("rx_model", rx_data, exp_rx);
        chk("sclk_edges", 32'(edges), 32'(2 * n));
        chk("mosi_bits", seen_mo, exp_mo);
        chk("cs_sel", 32'(cs_ok), 32'd1);
        chk("cs_other", 32'(oth_ok), 32'd1);
        chk("rx_stable", 32'(rx_ok), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("sclk_after", 32'(sclk), 32'(cp));
        chk("cs_after", 32'(cs_n), 32'({NCS{1'b1}}));
    endtask

    initial begin
        logic [31:0] grx;
        int glat, gap, cnt, dcount;

        tbl[0] = '{32'h0000_00A5, 8, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                   32'h0, 32'h0000_00A5, 38};
        tbl[1] = '{32'h0000_1234, 16, 1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                   32'hFFFF_FFFF, 32'h0000_FFFF, 105};
        tbl[2] = '{32'hFFFF_FABC, 12, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                   32'h0, 32'h0000_0ABC, 27};
        tbl[3] = '{32'h0000_003C, 8, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                   32'h0, 32'h0000_003C, 19};
        tbl[4] = '{32'h0000_0001, 1, 5, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                   32'h0, 32'h0000_0001, 20};
        tbl[5] = '{32'hDEAD_BEEF, 32, 3, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                   32'h0, 32'hDEAD_BEEF, 67};
        tbl[6] = '{32'h0, 8, 4, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                   32'h0000_00C1, 32'h0000_0083, 38};

        rst = 1'b1; start = 1'b0; tx_data = '0; frame_len = '0;
        cs_addr = '0; clk_div = '0; cpol = 1'b0; cpha = 1'b0;
        lsb_first = 1'b0; idle_mosi = 1'b0; loop_en = 1'b0; miso_drv = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx", rx_data, 32'd0);
        chk("rst_cs", 32'(cs_n), 32'({NCS{1'b1}}));
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_frame(tbl[v].tx, tbl[v].n, tbl[v].csa, tbl[v].div,
                      tbl[v].cp, tbl[v].ch, tbl[v].lsb, tbl[v].im,
                      tbl[v].lp, tbl[v].sw, grx, glat);
            chk($sformatf("tbl%0d_rx", v), grx, tbl[v].exp_rx);
            chk($sformatf("tbl%0d_lat", v), 32'(glat), 32'(tbl[v].exp_lat));
        end

        // Start mid-XFER is ignored; start on the done cycle is accepted.
        tx_data = 32'hA5; frame_len = 5'd7; cs_addr = 3'd2; clk_div = 8'd1;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; idle_mosi = 1'b0;
        loop_en = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        start = 1'b1; tx_data = 32'h0;
        @(negedge clk); start = 1'b0;
        chk("mid_ignored", 32'(busy), 32'd1);
        gap = 0; cnt = 0;
        while (!done && cnt < 100) begin
            @(negedge clk); cnt++;
            if (cs_n[2]) gap++; else gap = 0;
        end
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_rx1", rx_data, 32'h0000_00A5);
        tx_data = 32'h5A; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("b2b_accept", 32'(busy), 32'd1);
        chk("b2b_cs_low", 32'(cs_n[2]), 32'd0);
        chk("b2b_gap", 32'(gap), 32'(1 + 2));
        cnt = 0;
        while (!done && cnt < 100) begin @(negedge clk); cnt++; end
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_rx2", rx_data, 32'h0000_005A);
        repeat (5) @(negedge clk);
        chk("no_queue", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of bit 5 of an 8-bit frame.
        tx_data = 32'hC3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (22) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_cs", 32'(cs_n), 32'({NCS{1'b1}}));
        chk("arst_sclk", 32'(sclk), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rx", rx_data, 32'd0);
        @(negedge clk); rst = 1'b0;
        dcount = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("arst_no_done", 32'(dcount), 32'd0);
        chk("arst_rx_hold", rx_data, 32'd0);

        for (int r = 0; r < 20; r++) begin
            run_frame($urandom, $urandom_range(1, 32), $urandom_range(0, 7),
                      $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                      grx, glat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
